// File: rtl/spi_define.sv
// Shared SPI definitions: frame-width encodings, target FSM
// states and frame-size helpers.
package spi_define;

    localparam logic [1:0] SPI_TRANS_8_BITS  = 2'b00;
    localparam logic [1:0] SPI_TRANS_16_BITS = 2'b01;
    localparam logic [1:0] SPI_TRANS_24_BITS = 2'b10;
    localparam logic [1:0] SPI_TRANS_32_BITS = 2'b11;

    localparam int SPI_SLV_CNT_WIDTH = 6;

    typedef logic [SPI_SLV_CNT_WIDTH-1:0] spi_cnt_t;

    typedef enum logic {
        SPI_SLV_IDLE   = 1'b0,
        SPI_SLV_ACTIVE = 1'b1
    } spi_slv_state_e;

    // Number of bits in a frame for a given width code.
    function automatic spi_cnt_t spi_frame_bits(input logic [1:0] dtb);
        return spi_cnt_t'({dtb, 3'b000}) + spi_cnt_t'(8);
    endfunction

    // Mask covering the low n bits of a 32-bit word.
    function automatic logic [31:0] spi_frame_mask(input spi_cnt_t n);
        if (n >= spi_cnt_t'(32))
            return '1;
        return (32'd1 << n) - 32'd1;
    endfunction

endpackage

// File: rtl/spi_slave_sync.sv
// Pad-input synchronisers for the SPI target, plus
// single-cycle edge pulses for sck and cs_n.
module spi_slave_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sck,
    input  logic cs_n,
    input  logic mosi,
    output logic sck_rise,
    output logic sck_fall,
    output logic cs_rise,
    output logic cs_fall,
    output logic mosi_s
);

    logic [SYNC_STAGES-1:0] sck_q;
    logic [SYNC_STAGES-1:0] cs_q;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic                   sck_d;
    logic                   cs_d;
    logic                   sck_s;
    logic                   cs_s;

    assign sck_s  = sck_q[SYNC_STAGES-1];
    assign cs_s   = cs_q[SYNC_STAGES-1];
    assign mosi_s = mosi_q[SYNC_STAGES-1];

    // Shift pad values through the synchroniser chains; cs_n idles deselected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_q  <= '0;
            cs_q   <= '1;
            mosi_q <= '0;
            sck_d  <= 1'b0;
            cs_d   <= 1'b1;
        end else begin
            sck_q  <= {sck_q[SYNC_STAGES-2:0], sck};
            cs_q   <= {cs_q[SYNC_STAGES-2:0], cs_n};
            mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
            sck_d  <= sck_s;
            cs_d   <= cs_s;
        end
    end

    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;
    assign cs_rise  = cs_s & ~cs_d;
    assign cs_fall  = ~cs_s & cs_d;

endmodule

// File: rtl/spi_slave_core.sv
// SPI target core for modes 0-3 with 8/16/24/32-bit frames,
// a single-entry TX holding register and an RX holding register.
module spi_slave_core
    import spi_define::*;
#(
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] TX_FILL     = '0
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        en_i,
    input  logic        cpol_i,
    input  logic        cpha_i,
    input  logic        lsb_i,
    input  logic [1:0]  dtb_i,
    input  logic        clr_i,
    input  logic        sck_i,
    input  logic        cs_n_i,
    input  logic        mosi_i,
    output logic        miso_o,
    output logic        miso_en_o,
    input  logic        tx_valid_i,
    output logic        tx_ready_o,
    input  logic [31:0] tx_data_i,
    output logic        rx_valid_o,
    input  logic        rx_ready_i,
    output logic [31:0] rx_data_o,
    output logic        busy_o,
    output logic        ovf_o,
    output logic        udf_o
);

    logic sck_rise, sck_fall, cs_rise, cs_fall, mosi_s;

    spi_slave_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk     (clk_i),
        .rst_n   (rst_n_i),
        .sck     (sck_i),
        .cs_n    (cs_n_i),
        .mosi    (mosi_i),
        .sck_rise(sck_rise),
        .sck_fall(sck_fall),
        .cs_rise (cs_rise),
        .cs_fall (cs_fall),
        .mosi_s  (mosi_s)
    );

    spi_slv_state_e state;
    logic [1:0]     dtb_q;
    spi_cnt_t       cnt;
    logic [31:0]    tx_sh, rx_sh, tx_hold;
    logic           tx_full, first_lead, done;

    logic           lead, trail, start, stop, act;
    logic           samp_ev, shft_ev, last, reload;
    spi_cnt_t       n_new, n_cur;
    logic [31:0]    tx_src, tx_load, rx_nxt, rx_word;

    // Decode edge roles, frame events and the next shifter contents.
    always_comb begin
        lead    = cpol_i ? sck_fall : sck_rise;
        trail   = cpol_i ? sck_rise : sck_fall;
        start   = (state == SPI_SLV_IDLE) && cs_fall && en_i;
        stop    = (state == SPI_SLV_ACTIVE) && (cs_rise || !en_i);
        act     = (state == SPI_SLV_ACTIVE) && !stop;
        samp_ev = act && (cpha_i ? trail : lead) && (cnt != '0);
        shft_ev = act && (cpha_i ? lead : trail);
        last    = samp_ev && (cnt == spi_cnt_t'(1));
        reload  = start || (last && cpha_i) || (shft_ev && !cpha_i && done);
        n_new   = spi_frame_bits(dtb_i);
        n_cur   = spi_frame_bits(dtb_q);
        tx_src  = tx_full ? tx_hold : TX_FILL;
        tx_load = lsb_i ? (tx_src & spi_frame_mask(n_new))
                        : (tx_src << (spi_cnt_t'(32) - n_new));
        rx_nxt  = lsb_i ? {mosi_s, rx_sh[31:1]} : {rx_sh[30:0], mosi_s};
        rx_word = lsb_i ? (rx_nxt >> (spi_cnt_t'(32) - n_cur))
                        : (rx_nxt & spi_frame_mask(n_cur));
    end

    // Frame FSM: state, bit counter and both shifters.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= SPI_SLV_IDLE;
            dtb_q      <= SPI_TRANS_8_BITS;
            cnt        <= '0;
            tx_sh      <= '0;
            rx_sh      <= '0;
            first_lead <= 1'b0;
            done       <= 1'b0;
        end else if (stop) begin
            state      <= SPI_SLV_IDLE;
            cnt        <= '0;
            rx_sh      <= '0;
            first_lead <= 1'b0;
            done       <= 1'b0;
        end else begin
            if (start)
                state <= SPI_SLV_ACTIVE;
            if (reload) begin
                dtb_q      <= dtb_i;
                cnt        <= n_new;
                tx_sh      <= tx_load;
                rx_sh      <= '0;
                first_lead <= cpha_i;
                done       <= 1'b0;
            end else if (samp_ev) begin
                rx_sh <= last ? '0 : rx_nxt;
                cnt   <= cnt - spi_cnt_t'(1);
                done  <= last;
            end else if (shft_ev) begin
                if (first_lead)
                    first_lead <= 1'b0;
                else
                    tx_sh <= lsb_i ? (tx_sh >> 1) : (tx_sh << 1);
            end
        end
    end

    // TX holding register and sticky underflow flag.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tx_hold <= '0;
            tx_full <= 1'b0;
            udf_o   <= 1'b0;
        end else begin
            if (reload && tx_full)
                tx_full <= 1'b0;
            else if (tx_valid_i && !tx_full) begin
                tx_hold <= tx_data_i;
                tx_full <= 1'b1;
            end
            if (reload && !tx_full)
                udf_o <= 1'b1;
            else if (clr_i)
                udf_o <= 1'b0;
        end
    end

    // RX holding register and sticky overflow flag.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rx_valid_o <= 1'b0;
            rx_data_o  <= '0;
            ovf_o      <= 1'b0;
        end else begin
            if (last) begin
                if (rx_valid_o && !rx_ready_i)
                    ovf_o <= 1'b1;
                else begin
                    rx_data_o  <= rx_word;
                    rx_valid_o <= 1'b1;
                end
            end else if (rx_valid_o && rx_ready_i)
                rx_valid_o <= 1'b0;
            if (clr_i && !(last && rx_valid_o && !rx_ready_i))
                ovf_o <= 1'b0;
        end
    end

    assign miso_o     = lsb_i ? tx_sh[0] : tx_sh[31];
    assign miso_en_o  = (state == SPI_SLV_ACTIVE);
    assign busy_o     = (state == SPI_SLV_ACTIVE);
    assign tx_ready_o = !tx_full;

endmodule

// File: tb/tb_spi_slave_core.sv
// Self-checking bench for spi_slave_core: vector table over
// modes/widths plus hand sequences for multi-frame corner cases.
module tb_spi_slave_core;

    localparam int HALF = 60;

    logic        clk = 1'b0;
    logic        rst_n, en, cpol, cpha, lsb, clr;
    logic [1:0]  dtb;
    logic        sck, cs_n, mosi, miso, miso_en;
    logic        tx_valid, tx_ready, rx_valid, rx_ready;
    logic [31:0] tx_data, rx_data;
    logic        busy, ovf, udf;

    int          errors = 0;
    int          checks = 0;
    int          rx_seen = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic        cpol;
        logic        cpha;
        logic        lsb;
        logic [1:0]  dtb;
        logic [31:0] tx;
        logic [31:0] mo;
        logic [31:0] rx;
        logic [31:0] mi;
    } vec_t;

    vec_t vt[6];

    always #5 clk = ~clk;

    spi_slave_core #(
        .SYNC_STAGES(2),
        .TX_FILL    (32'h0)
    ) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .en_i      (en),
        .cpol_i    (cpol),
        .cpha_i    (cpha),
        .lsb_i     (lsb),
        .dtb_i     (dtb),
        .clr_i     (clr),
        .sck_i     (sck),
        .cs_n_i    (cs_n),
        .mosi_i    (mosi),
        .miso_o    (miso),
        .miso_en_o (miso_en),
        .tx_valid_i(tx_valid),
        .tx_ready_o(tx_ready),
        .tx_data_i (tx_data),
        .rx_valid_o(rx_valid),
        .rx_ready_i(rx_ready),
        .rx_data_o (rx_data),
        .busy_o    (busy),
        .ovf_o     (ovf),
        .udf_o     (udf)
    );

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    // Scoreboard: each word the consumer takes must match the queue head.
    always @(negedge clk) begin
        if (rst_n && rx_valid && rx_ready) begin
            rx_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rx_unexpected: got %h want none", rx_data);
            end else begin
                check("rx_word", rx_data, exp_q.pop_front());
            end
        end
    end

    task automatic write_tx(input logic [31:0] d);
        check("tx_ready", {31'b0, tx_ready}, 32'd1);
        tx_valid = 1'b1;
        tx_data  = d;
        #10;
        tx_valid = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        #10;
        clr = 1'b0;
    endtask

    task automatic cs_low();
        cs_n = 1'b0;
        #(2*HALF);
    endtask

    task automatic cs_high();
        #HALF;
        cs_n = 1'b1;
        #(2*HALF);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++)
            @(negedge clk);
        check("rx_drain", exp_q.size(), 0);
    endtask

    // Master side of one frame; nclk bits are clocked out of n.
    task automatic xfer(input int n, input int nclk, input logic [31:0] mo,
                        input bit skip_trail, output logic [31:0] mi);
        mi = '0;
        for (int i = 0; i < nclk; i++) begin
            int b;
            b = lsb ? i : n - 1 - i;
            if (!cpha) begin
                mosi = mo[b];
                #HALF;
                mi[b] = miso;
                sck = ~cpol;
                #HALF;
                if (!(skip_trail && i == nclk - 1))
                    sck = cpol;
            end else begin
                sck  = ~cpol;
                mosi = mo[b];
                #HALF;
                mi[b] = miso;
                sck = cpol;
                #HALF;
            end
        end
    endtask

    initial begin
        logic [31:0] mi, mi2;
        int          n, base;

        vt[0] = '{1'b0, 1'b0, 1'b0, 2'd0, 32'h000000A5, 32'h0000003C,
                  32'h0000003C, 32'h000000A5};
        vt[1] = '{1'b0, 1'b1, 1'b1, 2'd3, 32'hDEADBEEF, 32'h12345678,
                  32'h12345678, 32'hDEADBEEF};
        vt[2] = '{1'b1, 1'b0, 1'b1, 2'd3, 32'hDEADBEEF, 32'h12345678,
                  32'h12345678, 32'hDEADBEEF};
        vt[3] = '{1'b1, 1'b1, 1'b1, 2'd3, 32'hDEADBEEF, 32'h12345678,
                  32'h12345678, 32'hDEADBEEF};
        vt[4] = '{1'b1, 1'b1, 1'b0, 2'd2, 32'hAABBCCDD, 32'h00C0FFEE,
                  32'h00C0FFEE, 32'h00BBCCDD};
        vt[5] = '{1'b0, 1'b0, 1'b1, 2'd1, 32'h12345ACE, 32'h00008001,
                  32'h00008001, 32'h00005ACE};

        rst_n = 1'b0; en = 1'b1; cpol = 1'b0; cpha = 1'b0; lsb = 1'b0;
        dtb = 2'd0; clr = 1'b0; sck = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        tx_valid = 1'b0; tx_data = '0; rx_ready = 1'b1;
        #30;
        check("rst_miso", {31'b0, miso}, 32'd0);
        check("rst_miso_en", {31'b0, miso_en}, 32'd0);
        check("rst_rx_valid", {31'b0, rx_valid}, 32'd0);
        check("rst_rx_data", rx_data, 32'd0);
        check("rst_flags", {29'b0, busy, ovf, udf}, 32'd0);
        check("rst_tx_ready", {31'b0, tx_ready}, 32'd1);
        rst_n = 1'b1;
        #20;

        for (int v = 0; v < 6; v++) begin
            cpol = vt[v].cpol; cpha = vt[v].cpha;
            lsb  = vt[v].lsb;  dtb  = vt[v].dtb;
            sck  = cpol;
            n    = 8 * (int'(vt[v].dtb) + 1);
            #(2*HALF);
            write_tx(vt[v].tx);
            cs_low();
            check("busy_active", {31'b0, busy}, 32'd1);
            exp_q.push_back(vt[v].rx);
            xfer(n, n, vt[v].mo, 1'b0, mi);
            cs_high();
            check($sformatf("miso_vec%0d", v), mi, vt[v].mi);
            wait_drain();
            pulse_clr();
        end

        // Mode 0 single frame: no underflow before the closing edge.
        cpol = 1'b0; cpha = 1'b0; lsb = 1'b0; dtb = 2'd0; sck = 1'b0;
        #(2*HALF);
        base = rx_seen;
        write_tx(32'hA5);
        cs_low();
        exp_q.push_back(32'h3C);
        xfer(8, 8, 32'h3C, 1'b1, mi);
        #HALF;
        check("m0_udf", {31'b0, udf}, 32'd0);
        check("m0_miso_en", {31'b0, miso_en}, 32'd1);
        sck = 1'b0;
        cs_high();
        check("m0_miso", mi, 32'hA5);
        wait_drain();
        check("m0_rx_count", rx_seen - base, 1);
        pulse_clr();

        // Back-to-back 16-bit frames in one CS window.
        dtb = 2'd1;
        base = rx_seen;
        write_tx(32'h1111);
        cs_low();
        write_tx(32'h2222);
        exp_q.push_back(32'hA1B2);
        exp_q.push_back(32'hC3D4);
        xfer(16, 16, 32'hA1B2, 1'b0, mi);
        xfer(16, 16, 32'hC3D4, 1'b1, mi2);
        #HALF;
        check("b2b_udf", {31'b0, udf}, 32'd0);
        sck = 1'b0;
        cs_high();
        check("b2b_miso1", mi, 32'h1111);
        check("b2b_miso2", mi2, 32'h2222);
        wait_drain();
        check("b2b_rx_count", rx_seen - base, 2);
        pulse_clr();

        // Underflow: no TX word offered.
        dtb = 2'd0;
        cs_low();
        exp_q.push_back(32'h55);
        xfer(8, 8, 32'h55, 1'b0, mi);
        cs_high();
        check("udf_miso", mi, 32'h0);
        check("udf_set", {31'b0, udf}, 32'd1);
        pulse_clr();
        check("udf_clr", {31'b0, udf}, 32'd0);
        wait_drain();

        // Overflow: consumer stalled across two frames.
        rx_ready = 1'b0;
        base = rx_seen;
        cs_low();
        exp_q.push_back(32'h01);
        xfer(8, 8, 32'h01, 1'b0, mi);
        xfer(8, 8, 32'h02, 1'b0, mi);
        cs_high();
        check("ovf_valid", {31'b0, rx_valid}, 32'd1);
        check("ovf_data", rx_data, 32'h01);
        check("ovf_set", {31'b0, ovf}, 32'd1);
        pulse_clr();
        check("ovf_clr", {31'b0, ovf}, 32'd0);
        rx_ready = 1'b1;
        wait_drain();
        check("ovf_rx_count", rx_seen - base, 1);

        // Abort after 5 bits, then a full frame.
        base = rx_seen;
        cs_low();
        xfer(8, 5, 32'hFF, 1'b0, mi);
        check("abort_busy_mid", {31'b0, busy}, 32'd1);
        cs_high();
        check("abort_busy_drop", {31'b0, busy}, 32'd0);
        cs_low();
        exp_q.push_back(32'h7E);
        xfer(8, 8, 32'h7E, 1'b0, mi);
        cs_high();
        wait_drain();
        check("abort_rx_count", rx_seen - base, 1);
        check("abort_rx_data", rx_data, 32'h7E);

        // Asynchronous reset in the middle of a frame.
        cs_low();
        xfer(8, 3, 32'hC3, 1'b0, mi);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_busy", {31'b0, busy}, 32'd0);
        check("arst_miso", {30'b0, miso, miso_en}, 32'd0);
        check("arst_rx", {31'b0, rx_valid}, 32'd0);
        check("arst_rx_data", rx_data, 32'd0);
        check("arst_flags", {30'b0, ovf, udf}, 32'd0);
        check("arst_tx_ready", {31'b0, tx_ready}, 32'd1);
        #6;
        cs_n = 1'b1;
        #20;
        rst_n = 1'b1;
        #50;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
